// File: rtl/user_wb_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : user_wb_gpio_ctrl
// Description : Wishbone GPIO block with synchronized inputs and W1C edge IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module user_wb_gpio_ctrl #(
    parameter int          GPIO_W    = 32,
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter logic [31:0] ID_VALUE  = 32'h4750_494F
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [GPIO_W-1:0] io_in,
    output logic [GPIO_W-1:0] io_out,
    output logic [GPIO_W-1:0] io_oeb,
    output logic [2:0]        user_irq
);
    typedef enum logic [0:0] {IDLE = 1'b0, ACK = 1'b1} state_t;

    localparam logic [2:0] REG_OUT  = 3'd0;
    localparam logic [2:0] REG_OEB  = 3'd1;
    localparam logic [2:0] REG_IN   = 3'd2;
    localparam logic [2:0] REG_RISE = 3'd3;
    localparam logic [2:0] REG_FALL = 3'd4;
    localparam logic [2:0] REG_STAT = 3'd5;
    localparam logic [2:0] REG_ID   = 3'd7;

    state_t            state;
    logic [GPIO_W-1:0] out_reg, oeb_reg, rise_en, fall_en, irq_stat;
    logic [GPIO_W-1:0] sync1, sync2, prev;
    logic [1:0]        warm;
    logic              irq_q;

    logic              req, in_window, wr_hit;
    logic [2:0]        reg_sel;
    logic [31:0]       byte_mask, rd_data;
    logic [GPIO_W-1:0] mask_n, wdat_n, w1c_clr, rise, fall, edge_set;
    logic              unused_adr;

    // ack is only high in ACK, so being in IDLE already implies !ack
    assign req       = wbs_cyc_i & wbs_stb_i & (state == IDLE);
    assign in_window = (wbs_adr_i[31:5] == ADDR_BASE[31:5]);
    assign wr_hit    = req & wbs_we_i & in_window;
    assign reg_sel   = wbs_adr_i[4:2];
    assign byte_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                        {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign mask_n    = byte_mask[GPIO_W-1:0];
    assign wdat_n    = wbs_dat_i[GPIO_W-1:0];
    assign unused_adr = &{1'b0, wbs_adr_i[1:0]};

    assign w1c_clr  = (wr_hit && reg_sel == REG_STAT) ? (wdat_n & mask_n) : '0;
    assign rise     = sync2 & ~prev;
    assign fall     = ~sync2 & prev;
    // Edges are ignored until the synchronizer has flushed its reset contents
    assign edge_set = (warm == 2'd3) ? ((rise & rise_en) | (fall & fall_en)) : '0;

    always_comb begin
        rd_data = '0;
        if (in_window) begin
            case (reg_sel)
                REG_OUT:  rd_data = 32'(out_reg);
                REG_OEB:  rd_data = 32'(oeb_reg);
                REG_IN:   rd_data = 32'(sync2);
                REG_RISE: rd_data = 32'(rise_en);
                REG_FALL: rd_data = 32'(fall_en);
                REG_STAT: rd_data = 32'(irq_stat);
                REG_ID:   rd_data = ID_VALUE;
                default:  rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            out_reg   <= '0;
            oeb_reg   <= '1;
            rise_en   <= '0;
            fall_en   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= '0;
                    if (req) begin
                        state     <= ACK;
                        wbs_ack_o <= 1'b1;
                        if (!wbs_we_i) wbs_dat_o <= rd_data;
                        if (wr_hit) begin
                            case (reg_sel)
                                REG_OUT:  out_reg <= (out_reg & ~mask_n) | (wdat_n & mask_n);
                                REG_OEB:  oeb_reg <= (oeb_reg & ~mask_n) | (wdat_n & mask_n);
                                REG_RISE: rise_en <= (rise_en & ~mask_n) | (wdat_n & mask_n);
                                REG_FALL: fall_en <= (fall_en & ~mask_n) | (wdat_n & mask_n);
                                default: ;
                            endcase
                        end
                    end
                end
                ACK: begin
                    state     <= IDLE;
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= '0;
                end
                default: begin
                    state     <= IDLE;
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            warm     <= 2'd0;
            irq_stat <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync1    <= io_in;
            sync2    <= sync1;
            prev     <= sync2;
            if (warm != 2'd3) warm <= warm + 2'd1;
            // set has priority over a simultaneous W1C clear
            irq_stat <= (irq_stat & ~w1c_clr) | edge_set;
            irq_q    <= |irq_stat;
        end
    end

    assign io_out   = out_reg;
    assign io_oeb   = oeb_reg;
    assign user_irq = {2'b00, irq_q};

endmodule
`default_nettype wire

// File: tb/tb_user_wb_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_wb_gpio_ctrl
// Description : Self-checking bench: vector table, corner sequences, random vs model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_user_wb_gpio_ctrl;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] ID   = 32'h4750_494F;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0, io_in = '0;
    logic        ack;
    logic [31:0] dat_o, io_out, io_oeb;
    logic [2:0]  user_irq;

    int checks = 0;
    int errors = 0;

    // Behavioural register-file model
    logic [31:0] m_out, m_oeb, m_rise, m_fall, m_stat, m_pins;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[14];

    always #5 clk = ~clk;

    user_wb_gpio_ctrl dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .user_irq  (user_irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:5] != BASE[31:5]) return 32'h0;
        case (a[4:2])
            3'd0: return m_out;
            3'd1: return m_oeb;
            3'd2: return m_pins;
            3'd3: return m_rise;
            3'd4: return m_fall;
            3'd5: return m_stat;
            3'd7: return ID;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = bmask(s);
        if (a[31:5] == BASE[31:5]) begin
            case (a[4:2])
                3'd0: m_out  = (m_out  & ~m) | (d & m);
                3'd1: m_oeb  = (m_oeb  & ~m) | (d & m);
                3'd3: m_rise = (m_rise & ~m) | (d & m);
                3'd4: m_fall = (m_fall & ~m) | (d & m);
                3'd5: m_stat = m_stat & ~(d & m);
                default: ;
            endcase
        end
    endtask

    task automatic model_pins(input logic [31:0] nv);
        m_stat = m_stat | ((nv & ~m_pins) & m_rise) | ((~nv & m_pins) & m_fall);
        m_pins = nv;
    endtask

    // One Wishbone transaction; ack is expected exactly one cycle after stb
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
        int lat;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack && lat < 8);
        rd = dat_o;
        check("ack_latency", lat, 1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        tbl[0]  = '{1'b0, BASE + 32'h1C, 32'h0,         4'hF, ID};
        tbl[1]  = '{1'b1, BASE + 32'h00, 32'hA5A5_1234, 4'b0010, 32'h0};
        tbl[2]  = '{1'b0, BASE + 32'h00, 32'h0,         4'hF, 32'h0000_1200};
        tbl[3]  = '{1'b1, BASE + 32'h04, 32'h0000_00F0, 4'b0001, 32'h0};
        tbl[4]  = '{1'b0, BASE + 32'h04, 32'h0,         4'hF, 32'hFFFF_FFF0};
        tbl[5]  = '{1'b1, BASE + 32'h18, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[6]  = '{1'b0, BASE + 32'h18, 32'h0,         4'hF, 32'h0};
        tbl[7]  = '{1'b1, BASE + 32'h1C, 32'h0,         4'hF, 32'h0};
        tbl[8]  = '{1'b0, BASE + 32'h1C, 32'h0,         4'hF, ID};
        tbl[9]  = '{1'b0, 32'h3000_0040, 32'h0,         4'hF, 32'h0};
        tbl[10] = '{1'b1, 32'h3000_0040, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[11] = '{1'b0, BASE + 32'h00, 32'h0,         4'hF, 32'h0000_1200};
        tbl[12] = '{1'b1, BASE + 32'h00, 32'hDEAD_BEEF, 4'b1001, 32'h0};
        tbl[13] = '{1'b0, BASE + 32'h00, 32'h0,         4'hF, 32'hDE00_12EF};

        // Reset values, with pins high and a RISE_EN write waiting at release
        io_in = '1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h0C; wdat = '1; sel = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_oeb", io_oeb, 32'hFFFF_FFFF);
        check("rst_out", io_out, 32'h0);
        check("rst_irq", user_irq, 3'b000);
        check("rst_ack", ack, 1'b0);
        check("rst_dat", dat_o, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_ack", ack, 1'b1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        check("warm_irq", user_irq, 3'b000);
        bus(1'b0, BASE + 32'h14, 0, 4'hF, rd); check("warm_stat", rd, 32'h0);
        bus(1'b0, BASE + 32'h0C, 0, 4'hF, rd); check("warm_rise_en", rd, 32'hFFFF_FFFF);
        bus(1'b0, BASE + 32'h1C, 0, 4'hF, rd); check("id", rd, ID);
        bus(1'b1, BASE + 32'h0C, 0, 4'hF, rd);
        io_in = '0;
        repeat (6) @(posedge clk);

        // Register map vectors
        for (int i = 0; i < 14; i++) begin
            bus(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, rd);
            if (!tbl[i].wr) check($sformatf("tbl_rd%0d", i), rd, tbl[i].exp);
        end
        check("tbl_io_out", io_out, 32'hDE00_12EF);
        check("tbl_io_oeb", io_oeb, 32'hFFFF_FFF0);

        // Input synchronizer latency
        @(negedge clk) io_in[3] = 1'b1;
        bus(1'b0, BASE + 32'h08, 0, 4'hF, rd); check("in_early", rd[3], 1'b0);
        repeat (3) @(posedge clk);
        bus(1'b0, BASE + 32'h08, 0, 4'hF, rd); check("in_late", rd, 32'h0000_0008);

        // Rising edge IRQ and W1C clear
        bus(1'b1, BASE + 32'h0C, 32'h1, 4'hF, rd);
        @(posedge clk); #1 io_in[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("edge_irq", user_irq, 3'b001);
        bus(1'b0, BASE + 32'h14, 0, 4'hF, rd); check("edge_stat", rd, 32'h1);
        bus(1'b1, BASE + 32'h14, 32'h1, 4'hF, rd);
        check("w1c_irq", user_irq, 3'b000);
        bus(1'b0, BASE + 32'h14, 0, 4'hF, rd); check("w1c_stat", rd, 32'h0);

        // Set and clear of bit 0 on the same edge
        @(posedge clk); #1 io_in[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1 io_in[0] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h14; wdat = 32'h1; sel = 4'hF;
        @(posedge clk); #1;
        check("coll_ack", ack, 1'b1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        bus(1'b0, BASE + 32'h14, 0, 4'hF, rd); check("coll_stat", rd, 32'h1);
        check("coll_irq", user_irq, 3'b001);

        // Reset asserted while ack is high
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; wdat = '1; sel = 4'hF;
        @(posedge clk); #1;
        check("midrst_ack_before", ack, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_ack", ack, 1'b0);
        check("midrst_out", io_out, 32'h0);
        check("midrst_irq", user_irq, 3'b000);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        io_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        m_out = '0; m_oeb = '1; m_rise = '0; m_fall = '0; m_stat = '0; m_pins = '0;

        // Randomized traffic against the model
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a, d, nv;
            logic [3:0]  s;
            a = BASE + {27'h0, 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 7) == 0) a = a + 32'h0000_0100;
            d = $urandom;
            s = 4'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    bus(1'b1, a, d, s, rd);
                    model_write(a, d, s);
                end
                1: begin
                    bus(1'b0, a, 0, 4'hF, rd);
                    check($sformatf("rnd_rd_%h", a), rd, model_read(a));
                end
                2: begin
                    nv = $urandom;
                    @(posedge clk); #1 io_in = nv;
                    model_pins(nv);
                    repeat (5) @(posedge clk);
                    #1;
                end
                default: begin
                    check("rnd_io_out", io_out, m_out);
                    check("rnd_io_oeb", io_oeb, m_oeb);
                    check("rnd_irq", user_irq, {2'b00, |m_stat});
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
